mmu_bus_arbiter: RTL

- Burst-aware round-robin arbiter that shares the single MMU-side AHB-style bus between NUM_MASTERS requesters (walker, I-side, D-side, DMA).
- Owns address-phase grant and data-phase owner tracking; downstream muxes steer HADDR/HTRANS/HWDATA and route HRDATA from its outputs.
- Never breaks a fixed-length burst; re-arbitrates only at burst boundaries while hready_i=1.

---
 rtl/mmu_pkg.sv | 33 +++
 rtl/mmu_rr_picker.sv | 26 ++
 rtl/mmu_bus_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// Shared AHB-style transfer/burst encodings and helpers for the MMU bus masters
// and the arbiter that shares the MMU-side bus between them.
package mmu_pkg;

   typedef logic [1:0] htrans_t;
   typedef logic [2:0] hburst_t;

   localparam htrans_t TRANSFER_IDLE   = 2'b00;
   localparam htrans_t TRANSFER_BUSY   = 2'b01;
   localparam htrans_t TRANSFER_NONSEQ = 2'b10;
   localparam htrans_t TRANSFER_SEQ    = 2'b11;

   localparam hburst_t BURST_SINGLE = 3'b000;
   localparam hburst_t BURST_INCR   = 3'b001;
   localparam hburst_t BURST_WRAP4  = 3'b010;
   localparam hburst_t BURST_INCR4  = 3'b011;
   localparam hburst_t BURST_WRAP8  = 3'b100;
   localparam hburst_t BURST_INCR8  = 3'b101;
   localparam hburst_t BURST_WRAP16 = 3'b110;
   localparam hburst_t BURST_INCR16 = 3'b111;

   // Beat count of a fixed-length burst; undefined-length INCR reports 0.
   function automatic logic [4:0] burst_beats(hburst_t burst);
      case (burst)
         BURST_SINGLE:               return 5'd1;
         BURST_WRAP4,  BURST_INCR4:  return 5'd4;
         BURST_WRAP8,  BURST_INCR8:  return 5'd8;
         BURST_WRAP16, BURST_INCR16: return 5'd16;
         default:                    return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/mmu_rr_picker.sv
// Combinational round-robin picker: first set request at or after 'start',
// wrapping, so the entry just below 'start' is considered last.
module mmu_rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic             valid,
   output logic [IDX_W-1:0] winner
);

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      valid  = 1'b0;
      winner = start;
      // Scan farthest-first so the closest requester overwrites earlier hits.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(start) + i) % N]) begin
            valid  = 1'b1;
            winner = IDX_W'((int'(start) + i) % N);
         end
      end
   end

endmodule

// File: rtl/mmu_bus_arbiter.sv
// Burst-aware round-robin arbiter for the MMU-side bus; re-arbitrates only at
// burst boundaries and tracks address-phase and data-phase ownership.
module mmu_bus_arbiter
   import mmu_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0,
   localparam int IDX_W         = $clog2(NUM_MASTERS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_MASTERS-1:0]   req_i,
   input  logic [2*NUM_MASTERS-1:0] htrans_i,
   input  logic [3*NUM_MASTERS-1:0] hburst_i,
   input  logic                     hready_i,
   output logic [NUM_MASTERS-1:0]   grant_o,
   output logic [IDX_W-1:0]         addr_owner_o,
   output logic [IDX_W-1:0]         data_owner_o,
   output logic [4:0]               beats_left_o
);

   localparam logic [IDX_W-1:0] DEFAULT_IDX = IDX_W'(DEFAULT_MASTER);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_MASTERS - 1);

   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]       addr_owner_q, addr_owner_d;
   logic [IDX_W-1:0]       data_owner_q;
   logic [4:0]             beats_q, beats_d;

   htrans_t          owner_trans;
   hburst_t          owner_burst;
   logic             owner_req;
   logic             active;
   logic             boundary;
   logic [IDX_W-1:0] search_start;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;

   assign owner_trans = htrans_i[2*int'(addr_owner_q) +: 2];
   assign owner_burst = hburst_i[3*int'(addr_owner_q) +: 3];
   assign owner_req   = req_i[addr_owner_q];
   assign active      = (owner_trans == TRANSFER_NONSEQ) || (owner_trans == TRANSFER_SEQ);
   assign search_start = (addr_owner_q == LAST_IDX) ? '0 : addr_owner_q + 1'b1;

   mmu_rr_picker #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req    (req_i),
      .start  (search_start),
      .valid  (pick_valid),
      .winner (pick_idx)
   );

   always_comb begin
      boundary = 1'b0;
      beats_d  = beats_q;
      case (owner_trans)
         TRANSFER_IDLE: begin
            boundary = 1'b1;
            beats_d  = '0;
         end
         TRANSFER_NONSEQ: begin
            boundary = (owner_burst == BURST_SINGLE);
            beats_d  = (burst_beats(owner_burst) == '0) ? '0 : burst_beats(owner_burst) - 1'b1;
         end
         TRANSFER_SEQ: begin
            // A stray SEQ past the end of a fixed burst still ends it.
            boundary = (beats_q == 5'd1) ||
                       ((beats_q == '0) && (owner_burst != BURST_INCR));
            beats_d  = (beats_q == '0) ? '0 : beats_q - 1'b1;
         end
         default: ;
      endcase
      if (active && (owner_burst == BURST_INCR) && !owner_req)
         boundary = 1'b1;

      addr_owner_d = addr_owner_q;
      if (boundary)
         addr_owner_d = pick_valid ? pick_idx : DEFAULT_IDX;
      grant_d               = '0;
      grant_d[addr_owner_d] = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q      <= NUM_MASTERS'(1) << DEFAULT_MASTER;
         addr_owner_q <= DEFAULT_IDX;
         data_owner_q <= DEFAULT_IDX;
         beats_q      <= '0;
      end else if (hready_i) begin
         grant_q      <= grant_d;
         addr_owner_q <= addr_owner_d;
         beats_q      <= beats_d;
         if (active)
            data_owner_q <= addr_owner_q;
      end
   end

   assign grant_o      = grant_q;
   assign addr_owner_o = addr_owner_q;
   assign data_owner_o = data_owner_q;
   assign beats_left_o = beats_q;

endmodule
